// File: rtl/mem_word_port_if.sv
// Bus bundle for mem_word_port: processor word-request side plus block-memory
// handshake side. The slave modport is the port's own view.
interface mem_word_port_if #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 16,
    parameter int BLK_W  = 64
);
    logic              cpuReq;
    logic              cpuWr;
    logic [ADDR_W-1:0] cpuAddr;
    logic [WORD_W-1:0] cpuWrData;
    logic              cacheInv;
    logic              cpuBusy;
    logic              cpuDone;
    logic [WORD_W-1:0] cpuRdData;
    logic              startReq;
    logic              isRd;
    logic [ADDR_W-1:0] inAddr;
    logic [BLK_W-1:0]  inData;
    logic [BLK_W-1:0]  outData;
    logic              reqFinish;

    modport slave (
        input  cpuReq, cpuWr, cpuAddr, cpuWrData, cacheInv, outData, reqFinish,
        output cpuBusy, cpuDone, cpuRdData, startReq, isRd, inAddr, inData
    );

    modport master (
        output cpuReq, cpuWr, cpuAddr, cpuWrData, cacheInv, outData, reqFinish,
        input  cpuBusy, cpuDone, cpuRdData, startReq, isRd, inAddr, inData
    );
endinterface

// File: rtl/mem_word_port.sv
// Word-to-block memory port with a single-entry block buffer; writes go through
// to memory as read-modify-write of the enclosing block.
module mem_word_port #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 16,
    parameter int BLK_W  = 64
) (
    input logic            clk,
    input logic            rstn,
    mem_word_port_if.slave bus
);
    localparam int WORDS = BLK_W / WORD_W;
    localparam int SEL_W = $clog2(WORDS);
    localparam int TAG_W = ADDR_W - SEL_W;

    typedef enum logic [1:0] {IDLE, FETCH, STORE, RESP} state_t;

    state_t            state;
    logic              blk_valid;
    logic [TAG_W-1:0]  blk_tag;
    logic [BLK_W-1:0]  blk_data;
    logic              inv_pend;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_data;

    function automatic logic [BLK_W-1:0] merge_word(input logic [BLK_W-1:0] blk,
                                                    input logic [SEL_W-1:0] sel,
                                                    input logic [WORD_W-1:0] word);
        logic [BLK_W-1:0] r;
        r = blk;
        r[int'(sel)*WORD_W +: WORD_W] = word;
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] pick_word(input logic [BLK_W-1:0] blk,
                                                    input logic [SEL_W-1:0] sel);
        return blk[int'(sel)*WORD_W +: WORD_W];
    endfunction

    logic [TAG_W-1:0] cpu_tag;
    logic [SEL_W-1:0] cpu_sel;
    logic             hit;
    logic [BLK_W-1:0] hit_merged;
    logic [BLK_W-1:0] fetch_merged;

    assign cpu_tag      = bus.cpuAddr[ADDR_W-1:SEL_W];
    assign cpu_sel      = bus.cpuAddr[SEL_W-1:0];
    // An invalidate arriving with the request forces the refill path.
    assign hit          = blk_valid && (blk_tag == cpu_tag) && !bus.cacheInv;
    assign hit_merged   = merge_word(blk_data, cpu_sel, bus.cpuWrData);
    assign fetch_merged = merge_word(bus.outData, req_addr[SEL_W-1:0], req_data);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            blk_valid     <= 1'b0;
            blk_tag       <= '0;
            blk_data      <= '0;
            inv_pend      <= 1'b0;
            req_wr        <= 1'b0;
            req_addr      <= '0;
            req_data      <= '0;
            bus.cpuBusy   <= 1'b0;
            bus.cpuDone   <= 1'b0;
            bus.cpuRdData <= '0;
            bus.startReq  <= 1'b0;
            bus.isRd      <= 1'b0;
            bus.inAddr    <= '0;
            bus.inData    <= '0;
        end else begin
            bus.startReq <= 1'b0;
            case (state)
                IDLE: begin
                    bus.cpuDone <= 1'b0;
                    if (bus.cpuReq) begin
                        req_wr      <= bus.cpuWr;
                        req_addr    <= bus.cpuAddr;
                        req_data    <= bus.cpuWrData;
                        bus.cpuBusy <= 1'b1;
                        bus.inAddr  <= {cpu_tag, {SEL_W{1'b0}}};
                        if (hit && !bus.cpuWr) begin
                            bus.cpuDone   <= 1'b1;
                            bus.cpuRdData <= pick_word(blk_data, cpu_sel);
                            state         <= RESP;
                        end else if (hit) begin
                            blk_data     <= hit_merged;
                            bus.inData   <= hit_merged;
                            bus.isRd     <= 1'b0;
                            bus.startReq <= 1'b1;
                            state        <= STORE;
                        end else begin
                            bus.isRd     <= 1'b1;
                            bus.startReq <= 1'b1;
                            state        <= FETCH;
                        end
                    end else if (bus.cacheInv) begin
                        blk_valid <= 1'b0;
                    end
                end
                FETCH: begin
                    if (bus.cacheInv) inv_pend <= 1'b1;
                    // A finish coincident with our own request pulse is stale.
                    if (bus.reqFinish && !bus.startReq) begin
                        blk_tag   <= req_addr[ADDR_W-1:SEL_W];
                        blk_valid <= 1'b1;
                        if (req_wr) begin
                            blk_data     <= fetch_merged;
                            bus.inData   <= fetch_merged;
                            bus.isRd     <= 1'b0;
                            bus.startReq <= 1'b1;
                            state        <= STORE;
                        end else begin
                            blk_data      <= bus.outData;
                            bus.cpuRdData <= pick_word(bus.outData, req_addr[SEL_W-1:0]);
                            bus.cpuDone   <= 1'b1;
                            state         <= RESP;
                        end
                    end
                end
                STORE: begin
                    if (bus.cacheInv) inv_pend <= 1'b1;
                    if (bus.reqFinish && !bus.startReq) begin
                        bus.cpuDone <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    bus.cpuDone <= 1'b0;
                    bus.cpuBusy <= 1'b0;
                    if (inv_pend || bus.cacheInv) blk_valid <= 1'b0;
                    inv_pend <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_word_port.md
# mem_word_port

Word-to-block memory port that sits between the processor core and one 64-bit block memory (instruction or data side). It turns single-word reads and writes into block-memory transactions using the startReq/reqFinish handshake. It holds a single-entry block buffer so that repeated accesses to one block complete without a memory transaction. Writes go through to memory using read-modify-write of the enclosing block.

## Interface
- ADDR_W, 16: width of word address (cpuAddr, inAddr)
- WORD_W, 16: processor word width
- BLK_W, 64: memory block width; BLK_W/WORD_W (WORDS) must be a power of two ≥2, SEL_W = log2(WORDS)

- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- cpuReq  in  1  request strobe; accepted only when cpuBusy=0
- cpuWr  in  1  1=write, 0=read; sampled with cpuReq
- cpuAddr  in  ADDR_W  word address; sampled with cpuReq
- cpuWrData  in  WORD_W  write word; sampled with cpuReq
- cacheInv  in  1  invalidate block buffer
- cpuBusy  out  1  high whenever state≠IDLE
- cpuDone  out  1  one-cycle completion pulse
- cpuRdData  out  WORD_W  read result, valid while cpuDone=1
- startReq  out  1  one-cycle memory request pulse
- isRd  out  1  1=block read, 0=block write; held from startReq until reqFinish
- inAddr  out  ADDR_W  block address {cpuAddr[ADDR_W-1:SEL_W], SEL_W'b0}; held until reqFinish
- inData  out  BLK_W  write block; held until reqFinish
- outData  in  BLK_W  read block, valid in the reqFinish cycle
- reqFinish  in  1  memory completion pulse

## Operation
- Word i of a block occupies bits [i*WORD_W +: WORD_W], word 0 at the LSBs; i = addr[SEL_W-1:0].
- Buffer state: blkValid, blkTag (addr[ADDR_W-1:SEL_W]), blkData (BLK_W).
- A request is a hit when blkValid=1 and blkTag matches.
- FSM states are IDLE, FETCH, STORE, RESP. Transitions:
  - IDLE + cpuReq, read hit → RESP.
  - IDLE + cpuReq, write hit → STORE. The word is merged into blkData on acceptance.
  - IDLE + cpuReq, miss → FETCH (read or write).
  - FETCH + reqFinish: load blkData/blkTag from outData and set blkValid. Then a read goes → RESP. A write merges its word → STORE.
  - STORE + reqFinish → RESP.
  - RESP → IDLE unconditionally.
- Entering FETCH or STORE asserts startReq for exactly the next cycle. For STORE, inData = merged blkData.
- cpuReq while cpuBusy=1 is dropped silently. The captured address and data are unaffected.
- reqFinish is ignored in IDLE and RESP, and in the same cycle as startReq.
- cacheInv handling:
  - In IDLE without cpuReq, blkValid clears next cycle.
  - Together with cpuReq in IDLE, the request is forced to miss and refills normally.
  - While busy, the invalidate is latched as pending and clears blkValid on the RESP→IDLE transition.
- A memory write never modifies blkData beyond the merged word. The buffer always equals the last block written or read.

## Timing
- Reset values:
  - State IDLE, blkValid=0, pending inv=0.
  - All outputs 0: cpuBusy, cpuDone, cpuRdData, startReq, isRd, inAddr, inData.
  - blkTag and blkData are cleared to 0.
- Reset asserted mid-transaction aborts immediately. startReq/isRd drop to 0 and the buffer is invalid. A late reqFinish after reset is ignored.
- All latencies are from acceptance in cycle 0. N and M are cycles from startReq to reqFinish, each ≥1.
  - Read hit: cpuDone in cycle 1.
  - Read miss: startReq in cycle 1, reqFinish in 1+N, cpuDone in 2+N.
  - Write hit: startReq in cycle 1, cpuDone in 2+N.
  - Write miss: read startReq in cycle 1; write startReq in 2+N; cpuDone in 3+N+M.
- cpuBusy is high from cycle 1 through the cpuDone cycle. A new request can be accepted in the cycle after cpuDone.
- cpuRdData holds its last value outside cpuDone.

## Test plan
- Reset then read 0x0005, memory returns 0x4444_3333_2222_1111 after N=3 → startReq@1, inAddr=0x0004, isRd=1, cpuDone@5, cpuRdData=0x2222.
- Read 0x0007 immediately after → hit, no startReq, cpuDone@1, cpuRdData=0x4444.
- Write 0xBEEF to 0x0006 (hit) → startReq@1, isRd=0, inAddr=0x0004, inData=0x4444_BEEF_2222_1111; cpuDone the cycle after reqFinish.
- Write 0x1234 to 0x0010 (miss), read data all-zero → read transaction to 0x0010, then write inData=0x0000_0000_0000_1234; cpuDone at 3+N+M.
- cacheInv pulsed while busy, then re-read of the same block → original request completes normally; the re-read misses and issues startReq.
- rstn low during FETCH, then a spurious reqFinish → all outputs 0, state IDLE; the next read of the prior address misses.
